// File: rtl/led_pulse_pkg.sv
// Shared types and default sizing for the multi-channel LED pulse driver.
package led_pulse_pkg;

    localparam int DEF_N_CH     = 2;
    localparam int DEF_CODE_W   = 8;
    localparam int DEF_PERIOD_W = 8;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_RAMP_DIV = 4;
    localparam int DEF_MAX_ON   = 1024;

    // MAX_ON value that switches the on-time watchdog off
    localparam int MAX_ON_DISABLE = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_PULSE     = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } chan_state_t;

endpackage

// File: rtl/led_pulse_chan.sv
// One LED sink channel: soft current ramp, counted PWM burst, on-time watchdog.
// state        | meaning
// ST_IDLE      | waiting for start, all outputs low
// ST_RAMP_UP   | code climbs one step per RAMP_DIV cycles toward target
// ST_PULSE     | PWM burst at the target code
// ST_RAMP_DOWN | code falls to 0, done pulses on return to idle
// ST_FAULT     | watchdog tripped, outputs forced low until fault_clr
module led_pulse_chan
    import led_pulse_pkg::*;
#(
    parameter int CODE_W   = DEF_CODE_W,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RAMP_DIV = DEF_RAMP_DIV,
    parameter int MAX_ON   = DEF_MAX_ON
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                fault_clr,
    input  logic                half_cur,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [CODE_W-1:0]   target,
    input  logic [CNT_W-1:0]    pulses,
    output logic                drv_en,
    output logic                drv_pwm,
    output logic [CODE_W-1:0]   drv_code,
    output logic                busy,
    output logic                done,
    output logic                fault
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WD_W  = (MAX_ON > 1) ? $clog2(MAX_ON + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    chan_state_t         state, state_nxt;
    logic [CODE_W-1:0]   code, code_nxt, cfg_target;
    logic [DIV_W-1:0]    presc, presc_nxt;
    logic [PERIOD_W-1:0] pcnt, pcnt_nxt, cfg_period, cfg_duty;
    logic [CNT_W-1:0]    pulse_cnt, pulse_cnt_nxt, cfg_pulses;
    logic [WD_W-1:0]     wd, wd_nxt;
    logic                load_cfg, step, wd_trip;
    logic                drv_en_nxt, drv_pwm_nxt, busy_nxt, done_nxt, fault_nxt;
    logic [CODE_W-1:0]   drv_code_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            code       <= '0;
            presc      <= '0;
            pcnt       <= '0;
            pulse_cnt  <= '0;
            wd         <= '0;
            cfg_period <= '0;
            cfg_duty   <= '0;
            cfg_target <= '0;
            cfg_pulses <= '0;
            drv_en     <= 1'b0;
            drv_pwm    <= 1'b0;
            drv_code   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            presc     <= presc_nxt;
            pcnt      <= pcnt_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            wd        <= wd_nxt;
            if (load_cfg) begin
                cfg_period <= period;
                cfg_duty   <= duty;
                cfg_target <= target;
                cfg_pulses <= pulses;
            end
            drv_en   <= drv_en_nxt;
            drv_pwm  <= drv_pwm_nxt;
            drv_code <= drv_code_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            fault    <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        code_nxt      = code;
        presc_nxt     = presc;
        pcnt_nxt      = pcnt;
        pulse_cnt_nxt = pulse_cnt;
        load_cfg      = 1'b0;
        step          = (presc == DIV_LAST);
        wd_nxt        = '0;
        wd_trip       = 1'b0;
        // wd holds the high cycles seen before this one; this cycle makes wd+1
        if (drv_pwm) begin
            wd_nxt  = (wd == '1) ? wd : wd + 1'b1;
            wd_trip = (MAX_ON != MAX_ON_DISABLE) && ((int'(wd) + 1) >= MAX_ON);
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_RAMP_UP;
                    load_cfg      = 1'b1;
                    code_nxt      = '0;
                    presc_nxt     = '0;
                    pcnt_nxt      = '0;
                    pulse_cnt_nxt = '0;
                end
            end
            ST_RAMP_UP: begin
                if (stop) begin
                    state_nxt = ST_RAMP_DOWN;
                    presc_nxt = '0;
                end else if (code == cfg_target) begin
                    state_nxt     = ST_PULSE;
                    pcnt_nxt      = '0;
                    pulse_cnt_nxt = '0;
                end else begin
                    presc_nxt = step ? '0 : presc + 1'b1;
                    if (step && code != '1) code_nxt = code + 1'b1;
                end
            end
            ST_PULSE: begin
                if (stop) begin
                    state_nxt = ST_RAMP_DOWN;
                    presc_nxt = '0;
                end else if (pcnt == cfg_period) begin
                    pcnt_nxt      = '0;
                    pulse_cnt_nxt = (pulse_cnt == '1) ? pulse_cnt : pulse_cnt + 1'b1;
                    if (cfg_pulses != '0 && pulse_cnt_nxt == cfg_pulses) begin
                        state_nxt = ST_RAMP_DOWN;
                        presc_nxt = '0;
                    end
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                if (code == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    presc_nxt = step ? '0 : presc + 1'b1;
                    if (step) code_nxt = code - 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (wd_trip) begin
            state_nxt = ST_FAULT;
            code_nxt  = '0;
        end
    end

    // Outputs are computed from the next state so the registered copies line up with it
    always_comb begin
        drv_en_nxt   = (state_nxt == ST_RAMP_UP) || (state_nxt == ST_PULSE) ||
                       (state_nxt == ST_RAMP_DOWN);
        drv_pwm_nxt  = (state_nxt == ST_PULSE) && (pcnt_nxt < cfg_duty);
        drv_code_nxt = '0;
        if (drv_en_nxt) drv_code_nxt = half_cur ? (code_nxt >> 1) : code_nxt;
        busy_nxt     = (state_nxt != ST_IDLE);
        fault_nxt    = (state_nxt == ST_FAULT);
        done_nxt     = (state == ST_RAMP_DOWN) && (state_nxt == ST_IDLE);
    end

endmodule

// File: rtl/led_pulse_driver.sv
// Multi-channel LED sink controller: N_CH independent channels on packed buses.
module led_pulse_driver
    import led_pulse_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int CODE_W   = DEF_CODE_W,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RAMP_DIV = DEF_RAMP_DIV,
    parameter int MAX_ON   = DEF_MAX_ON
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            start,
    input  logic [N_CH-1:0]            stop,
    input  logic [N_CH-1:0]            fault_clr,
    input  logic [N_CH-1:0]            half_cur,
    input  logic [N_CH*PERIOD_W-1:0]   period,
    input  logic [N_CH*PERIOD_W-1:0]   duty,
    input  logic [N_CH*CODE_W-1:0]     target,
    input  logic [N_CH*CNT_W-1:0]      pulses,
    output logic [N_CH-1:0]            drv_en,
    output logic [N_CH-1:0]            drv_pwm,
    output logic [N_CH*CODE_W-1:0]     drv_code,
    output logic [N_CH-1:0]            busy,
    output logic [N_CH-1:0]            done,
    output logic [N_CH-1:0]            fault
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_pulse_chan #(
            .CODE_W   (CODE_W),
            .PERIOD_W (PERIOD_W),
            .CNT_W    (CNT_W),
            .RAMP_DIV (RAMP_DIV),
            .MAX_ON   (MAX_ON)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (start[i]),
            .stop      (stop[i]),
            .fault_clr (fault_clr[i]),
            .half_cur  (half_cur[i]),
            .period    (period[i*PERIOD_W +: PERIOD_W]),
            .duty      (duty[i*PERIOD_W +: PERIOD_W]),
            .target    (target[i*CODE_W +: CODE_W]),
            .pulses    (pulses[i*CNT_W +: CNT_W]),
            .drv_en    (drv_en[i]),
            .drv_pwm   (drv_pwm[i]),
            .drv_code  (drv_code[i*CODE_W +: CODE_W]),
            .busy      (busy[i]),
            .done      (done[i]),
            .fault     (fault[i])
        );
    end

endmodule

// File: tb/tb_led_pulse_driver.sv
// Bench for led_pulse_driver: each burst is planned as an expected waveform and compared per cycle.
module tb_led_pulse_driver;
    localparam int N_CH      = 2;
    localparam int CODE_W    = 8;
    localparam int PERIOD_W  = 8;
    localparam int CNT_W     = 8;
    localparam int RAMP_DIV  = 4;
    localparam int MAX_ON    = 50;
    localparam int PLAN_LEN  = 4096;
    localparam int PULSE_CAP = 2000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_CH-1:0]          start, stop, fault_clr, half_cur;
    logic [N_CH*PERIOD_W-1:0] period, duty;
    logic [N_CH*CODE_W-1:0]   target;
    logic [N_CH*CNT_W-1:0]    pulses;
    logic [N_CH-1:0]          drv_en, drv_pwm, busy, done, fault;
    logic [N_CH*CODE_W-1:0]   drv_code;

    led_pulse_driver #(
        .N_CH(N_CH), .CODE_W(CODE_W), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W),
        .RAMP_DIV(RAMP_DIV), .MAX_ON(MAX_ON)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .fault_clr(fault_clr),
        .half_cur(half_cur), .period(period), .duty(duty), .target(target),
        .pulses(pulses), .drv_en(drv_en), .drv_pwm(drv_pwm), .drv_code(drv_code),
        .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {PH_UP, PH_PULSE, PH_DOWN, PH_DONE, PH_FAULT} ph_t;
    typedef struct packed {
        ph_t        ph;
        logic [7:0] code;
        logic       pwm;
    } ent_t;

    ent_t pl [N_CH][PLAN_LEN];
    int   hd [N_CH] = '{default: 0};
    int   tl [N_CH] = '{default: 0};
    logic hc [N_CH] = '{default: 1'b0};
    int   hi_cnt [N_CH];
    int   done_cnt [N_CH];
    int   busy_cnt [N_CH];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int ch, input ph_t ph, input int code, input logic pwm);
        ent_t e;
        e.ph   = ph;
        e.code = 8'(code);
        e.pwm  = pwm;
        if (tl[ch] < PLAN_LEN) begin
            pl[ch][tl[ch]] = e;
            tl[ch]++;
        end
    endtask

    task automatic plan_down(input int ch, input int c);
        for (int v = c; v >= 1; v--)
            repeat (RAMP_DIV) push(ch, PH_DOWN, v, 1'b0);
        push(ch, PH_DOWN, 0, 1'b0);
        push(ch, PH_DONE, 0, 1'b0);
    endtask

    task automatic plan_burst(input int ch, input int p, input int d, input int t, input int n);
        int run, periods, len;
        bit tripped, hi;
        run = 0; periods = 0; len = 0; tripped = 0;
        hd[ch] = 0;
        tl[ch] = 0;
        for (int c = 0; c < t; c++)
            repeat (RAMP_DIV) push(ch, PH_UP, c, 1'b0);
        push(ch, PH_UP, t, 1'b0);
        while (!tripped) begin
            for (int k = 0; k <= p && !tripped; k++) begin
                hi  = (k < d);
                run = hi ? run + 1 : 0;
                push(ch, PH_PULSE, t, hi);
                len++;
                if (run == MAX_ON) begin
                    push(ch, PH_FAULT, 0, 1'b0);
                    tripped = 1;
                end
            end
            periods++;
            if ((n != 0 && periods == n) || len >= PULSE_CAP) break;
        end
        if (!tripped) plan_down(ch, t);
    endtask

    // Advance the plan across one clock edge using the inputs presented at that edge
    task automatic model_step();
        for (int ch = 0; ch < N_CH; ch++) begin
            ent_t cur;
            bit   idle;
            cur  = '0;
            idle = (hd[ch] >= tl[ch]);
            if (!idle) cur = pl[ch][hd[ch]];
            if (idle || cur.ph == PH_DONE) begin
                if (start[ch])
                    plan_burst(ch, int'(period[ch*PERIOD_W +: PERIOD_W]),
                               int'(duty[ch*PERIOD_W +: PERIOD_W]),
                               int'(target[ch*CODE_W +: CODE_W]),
                               int'(pulses[ch*CNT_W +: CNT_W]));
                else
                    hd[ch] = tl[ch];
            end else if (cur.ph == PH_FAULT) begin
                if (fault_clr[ch]) hd[ch] = tl[ch];
            end else if (stop[ch] && (cur.ph == PH_UP || cur.ph == PH_PULSE) &&
                         !(hd[ch] + 1 < tl[ch] && pl[ch][hd[ch]+1].ph == PH_FAULT)) begin
                hd[ch] = 0;
                tl[ch] = 0;
                plan_down(ch, int'(cur.code));
            end else begin
                hd[ch]++;
            end
            hc[ch] = half_cur[ch];
        end
    endtask

    // Packed as {busy, done, fault, en, pwm, code}
    function automatic logic [12:0] expv(input int ch);
        ent_t       e;
        logic [7:0] c;
        if (hd[ch] >= tl[ch]) return '0;
        e = pl[ch][hd[ch]];
        case (e.ph)
            PH_DONE:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
            PH_FAULT: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
            default: begin
                c = hc[ch] ? (e.code >> 1) : e.code;
                return {1'b1, 1'b0, 1'b0, 1'b1, e.pwm, c};
            end
        endcase
    endfunction

    function automatic logic [12:0] actv(input int ch);
        return {busy[ch], done[ch], fault[ch], drv_en[ch], drv_pwm[ch],
                drv_code[ch*CODE_W +: CODE_W]};
    endfunction

    function automatic bit in_pulse(input int ch);
        return (hd[ch] < tl[ch]) && (pl[ch][hd[ch]].ph == PH_PULSE);
    endfunction

    task automatic compare_all();
        for (int ch = 0; ch < N_CH; ch++)
            check($sformatf("ch%0d_cyc%0d", ch, cyc), 32'(actv(ch)), 32'(expv(ch)));
    endtask

    task automatic cycle(input logic [N_CH-1:0] st, input logic [N_CH-1:0] sp,
                         input logic [N_CH-1:0] fc);
        start     = st;
        stop      = sp;
        fault_clr = fc;
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
        for (int ch = 0; ch < N_CH; ch++) begin
            hi_cnt[ch]   += int'(drv_pwm[ch]);
            done_cnt[ch] += int'(done[ch]);
            busy_cnt[ch] += int'(busy[ch]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle('0, '0, '0);
    endtask

    task automatic clr_stats();
        for (int ch = 0; ch < N_CH; ch++) begin
            hi_cnt[ch]   = 0;
            done_cnt[ch] = 0;
            busy_cnt[ch] = 0;
        end
    endtask

    task automatic set_cfg(input int ch, input int p, input int d, input int t, input int n);
        period[ch*PERIOD_W +: PERIOD_W] = PERIOD_W'(p);
        duty[ch*PERIOD_W +: PERIOD_W]   = PERIOD_W'(d);
        target[ch*CODE_W +: CODE_W]     = CODE_W'(t);
        pulses[ch*CNT_W +: CNT_W]       = CNT_W'(n);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        start = '0; stop = '0; fault_clr = '0; half_cur = '0;
        period = '0; duty = '0; target = '0; pulses = '0;
        clr_stats();
        repeat (3) @(negedge clk);
        check("reset_state", 32'({drv_en, drv_pwm, drv_code, busy, done, fault}), 32'd0);
        rst = 1'b0;
        compare_all();

        // normal burst
        set_cfg(0, 9, 3, 4, 2);
        clr_stats();
        cycle(2'b01, 2'b00, 2'b00);
        check("en_rise", 32'(drv_en[0]), 32'd1);
        run(70);
        check("burst_hi", hi_cnt[0], 6);
        check("burst_done", done_cnt[0], 1);
        check("burst_busy", busy_cnt[0], 54);

        // stop while ramping up
        set_cfg(0, 9, 3, 8, 2);
        clr_stats();
        cycle(2'b01, 2'b00, 2'b00);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (drv_code[7:0] == 8'd2) found = 1;
            else cycle('0, '0, '0);
        end
        check("stop_reach2", 32'(found), 32'd1);
        cycle(2'b00, 2'b01, 2'b00);
        run(20);
        check("stop_hi", hi_cnt[0], 0);
        check("stop_done", done_cnt[0], 1);

        // watchdog
        set_cfg(0, 9, 20, 1, 0);
        clr_stats();
        cycle(2'b01, 2'b00, 2'b00);
        run(60);
        check("wd_hi", hi_cnt[0], MAX_ON);
        check("wd_fault", 32'(fault[0]), 32'd1);
        check("wd_outs", 32'({drv_pwm[0], drv_en[0], drv_code[7:0]}), 32'd0);
        cycle(2'b01, 2'b00, 2'b00);
        check("wd_start_ign", 32'({fault[0], busy[0]}), 32'b11);
        cycle(2'b00, 2'b00, 2'b01);
        check("wd_clr", 32'({fault[0], busy[0], done[0]}), 32'd0);

        // async reset in the middle of a burst
        set_cfg(0, 5, 2, 2, 3);
        cycle(2'b01, 2'b00, 2'b00);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (in_pulse(0)) found = 1;
            else cycle('0, '0, '0);
        end
        check("rst_reach_pulse", 32'(found), 32'd1);
        run(3);
        #2 rst = 1'b1;
        #1 check("async_rst", 32'({drv_en, drv_pwm, drv_code, busy, done, fault}), 32'd0);
        for (int ch = 0; ch < N_CH; ch++) begin
            hd[ch] = 0;
            tl[ch] = 0;
            hc[ch] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        clr_stats();
        cycle(2'b01, 2'b00, 2'b00);
        run(60);
        check("rst_rerun_done", done_cnt[0], 1);

        // independent channels, second start on busy ch0
        set_cfg(0, 4, 1, 3, 2);
        set_cfg(1, 7, 5, 6, 1);
        clr_stats();
        cycle(2'b11, 2'b00, 2'b00);
        run(3);
        set_cfg(0, 2, 2, 9, 4);
        cycle(2'b01, 2'b00, 2'b00);
        run(80);
        check("ind_done0", done_cnt[0], 1);
        check("ind_done1", done_cnt[1], 1);
        check("ind_hi0", hi_cnt[0], 2);
        check("ind_hi1", hi_cnt[1], 5);

        // half current on ch1
        half_cur = 2'b10;
        set_cfg(1, 3, 2, 200, 0);
        clr_stats();
        cycle(2'b10, 2'b00, 2'b00);
        found = 0;
        for (int i = 0; i < 900 && !found; i++) begin
            if (in_pulse(1)) found = 1;
            else cycle('0, '0, '0);
        end
        check("half_reach_pulse", 32'(found), 32'd1);
        run(2);
        check("half_code", 32'(drv_code[15:8]), 32'd100);
        half_cur = 2'b00;
        cycle('0, '0, '0);
        check("full_code", 32'(drv_code[15:8]), 32'd200);
        cycle(2'b00, 2'b10, 2'b00);
        run(820);
        check("half_done", done_cnt[1], 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [N_CH-1:0] st, sp, fc;
            for (int ch = 0; ch < N_CH; ch++) begin
                set_cfg(ch, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                        int'($urandom_range(0, 30)), int'($urandom_range(0, 5)));
                st[ch] = ($urandom_range(0, 19) == 0);
                sp[ch] = ($urandom_range(0, 39) == 0);
                fc[ch] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) half_cur[ch] = ~half_cur[ch];
            end
            cycle(st, sp, fc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
